bcg_writer: RTL
===============

BCG_WRITER -- requirements
Module: bcg_writer

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1: cycles from ram_addr presented to ram_rdata valid; legal values 1..3.
REQ-002 SHALL have port clk  in  1: single clock; all state on rising edge.
REQ-003 SHALL have port rst  in  1: asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid  in  1: command present.
REQ-005 SHALL have port cmd_ready  out  1: block can accept a command.
REQ-006 SHALL have port cmd_op  in  2: 0 SET_TILE, 1 SET_PAL, 2 WRITE_PIX, 3 FILL.
REQ-007 SHALL have port cmd_col  in  6: tile column.
REQ-008 SHALL have port cmd_row  in  5: tile row.
REQ-009 SHALL have port cmd_sel  in  1: SET_PAL nibble select; 1 = low nibble, 0 = high nibble.
REQ-010 SHALL have port cmd_addr  in  11: WRITE_PIX pattern offset.
REQ-011 SHALL have port cmd_data  in  8: write data.
REQ-012 SHALL have port ram_addr  out  13: VRAM write-side address.
REQ-013 SHALL have port ram_wdata  out  8: VRAM write data.
REQ-014 SHALL have port ram_we  out  1: VRAM write strobe.
REQ-015 SHALL have port ram_rdata  in  8: VRAM write-side read data.
REQ-016 SHALL have port busy  out  1: command in progress.
REQ-017 SHALL have port done  out  1: one-cycle pulse on the final write of a command.

Function
REQ-018 SHALL drive the VRAM write port of the dual-port VRAM; the background renderer owns the other port, and no arbitration is required.
REQ-019 SHALL accept a command on a rising edge with cmd_valid=1 and cmd_ready=1 (cycle N), registering all cmd_* fields.
REQ-020 SHALL drive cmd_ready=1 only in state IDLE, and SHALL drive busy as the inverse of cmd_ready.
REQ-021 SHALL use the states IDLE, WR, RD, MERGE and FILL.
REQ-022 SHALL implement SET_TILE as IDLE->WR: in cycle N+1, ram_addr={2'b10,col,row}, ram_wdata=data, ram_we=1 and done=1; then return to IDLE.
REQ-023 SHALL implement WRITE_PIX as IDLE->WR: in cycle N+1, ram_addr={2'b01,cmd_addr}, ram_we=1 and done=1; then return to IDLE.
REQ-024 SHALL implement SET_PAL as a read-modify-write at address {3'b110,col,row[3:0]}; row[4] is ignored.
REQ-025 SHALL, for SET_PAL, stay in RD for cycles N+1..N+RD_LATENCY with ram_we=0 and the address held.
REQ-026 SHALL, for SET_PAL, enter MERGE in cycle N+1+RD_LATENCY with ram_we=1 and done=1, then return to IDLE.
REQ-027 SHALL form the MERGE write data as follows: sel=1 gives {ram_rdata[7:4],data[3:0]}; sel=0 gives {data[3:0],ram_rdata[3:0]}.
REQ-028 SHALL implement FILL by writing data to all 2048 tile-map bytes using an 11-bit counter cnt, with ram_addr={2'b10,cnt}.
REQ-029 SHALL, for FILL, increment cnt from 0 to 2047, one write per cycle, in cycles N+1..N+2048, with ram_we=1 in every one of those cycles.
REQ-030 SHALL, for FILL, pulse done in cycle N+2048 and return to IDLE; cnt wrap-around is never reached.
REQ-031 SHALL ignore cmd_valid while busy; commands are not queued, and the cmd_* inputs may change freely while busy.
REQ-032 SHALL re-assert cmd_ready in the cycle after done; a back-to-back command is accepted on that edge.
REQ-033 SHALL, in IDLE, drive ram_addr=0, ram_wdata=0, ram_we=0 and done=0.
REQ-034 SHALL treat write data as 8-bit with no arithmetic, and SHALL truncate addresses exactly to the 13-bit fields above.

Reset
REQ-035 SHALL force the following while rst=0, regardless of clk: state=IDLE, cnt=0, ram_we=0, ram_addr=0, ram_wdata=0, done=0, cmd_ready=1, busy=0.
REQ-036 SHALL, on reset mid-command (including mid-FILL or in RD), abort with no further writes; already-written bytes remain.
REQ-037 SHALL accept a command on the first rising edge after rst deasserts.

Verification
REQ-038 SHALL be verified by SET_TILE col=5, row=3, data=0xA7 -> one write at 0x10A3 of 0xA7 in N+1, done in N+1, cmd_ready high in N+2.
REQ-039 SHALL be verified by SET_PAL col=2, row=0x11, sel=1, data=0x0C with ram_rdata=0x5F and RD_LATENCY=1 -> ram_we=0 in N+1, then a write of 0x5C at 0x1821 in N+2; with sel=0 -> 0xCF.
REQ-040 SHALL be verified by WRITE_PIX cmd_addr=0x7FF, data=0x3C -> a write at 0x0FFF of 0x3C.
REQ-041 SHALL be verified by FILL data=0x00 -> 2048 consecutive writes at 0x1000..0x17FF, done at N+2048, and cmd_valid pulses ignored throughout.
REQ-042 SHALL be verified by asserting rst=0 at cycle N+100 of a FILL -> ram_we=0 immediately (asynchronous), no further writes, and a new SET_TILE accepted after release.
REQ-043 SHALL be verified by holding cmd_valid high with two queued SET_TILEs -> accepts at N and N+2, no lost or duplicated writes.

Source files
------------

// File: rtl/bcg_writer.sv
// bcg_writer: write-side controller for the background VRAM.
//
// Accepts one command at a time and turns it into VRAM write-port traffic:
//   SET_TILE  (op 0) : one write of data to the tile map at {2'b10,col,row}
//   SET_PAL   (op 1) : read-modify-write of one palette nibble at
//                      {3'b110,col,row[3:0]}
//   WRITE_PIX (op 2) : one write of data to the pattern area at {2'b01,addr}
//   FILL      (op 3) : writes data to all 2048 tile-map bytes, one per cycle
//
// Ports
//   clk, rst            : clock; asynchronous active-low reset
//   cmd_valid/cmd_ready : command handshake
//   cmd_op, cmd_col, cmd_row, cmd_sel, cmd_addr, cmd_data : command fields
//   ram_addr, ram_wdata, ram_we, ram_rdata : VRAM write-side port
//   busy                : command in progress (inverse of cmd_ready)
//   done                : one-cycle pulse on the final write of a command
//   dbg_state           : current FSM state, for observation only
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is high only in IDLE; cmd_valid is ignored
// otherwise, and the cmd_* inputs may change freely once transferred since
// every field is registered on acceptance.
module bcg_writer #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_col,
  input  logic [4:0]  cmd_row,
  input  logic        cmd_sel,
  input  logic [10:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic [12:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    MERGE = 3'd3,
    FILL  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_SET_TILE  = 2'd0,
    OP_SET_PAL   = 2'd1,
    OP_WRITE_PIX = 2'd2,
    OP_FILL      = 2'd3
  } op_t;

  // Last value of the read-wait counter before the read data is valid.
  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

  state_t      state_q, state_d;
  logic [10:0] cnt_q,   cnt_d;
  logic [1:0]  lat_q,   lat_d;
  logic [1:0]  op_q,    op_d;
  logic [5:0]  col_q,   col_d;
  logic [4:0]  row_q,   row_d;
  logic        sel_q,   sel_d;
  logic [10:0] addr_q,  addr_d;
  logic [7:0]  data_q,  data_d;

  logic [12:0] pal_addr;

  // Palette entries ignore row[4]: two tile rows share one palette byte row.
  assign pal_addr  = {3'b110, col_q, row_q[3:0]};
  assign dbg_state = state_q;
  assign busy      = ~cmd_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    op_d      = op_q;
    col_d     = col_q;
    row_d     = row_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cmd_ready = 1'b0;
    ram_addr  = 13'd0;
    ram_wdata = 8'd0;
    ram_we    = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d   = cmd_op;
          col_d  = cmd_col;
          row_d  = cmd_row;
          sel_d  = cmd_sel;
          addr_d = cmd_addr;
          data_d = cmd_data;
          case (op_t'(cmd_op))
            OP_SET_PAL: begin
              state_d = RD;
              lat_d   = 2'd0;
            end
            OP_FILL: begin
              state_d = FILL;
              cnt_d   = 11'd0;
            end
            default: state_d = WR;
          endcase
        end
      end

      WR: begin
        ram_we    = 1'b1;
        done      = 1'b1;
        ram_wdata = data_q;
        if (op_t'(op_q) == OP_WRITE_PIX) ram_addr = {2'b01, addr_q};
        else                             ram_addr = {2'b10, col_q, row_q};
        state_d   = IDLE;
      end

      // Address is held while the read data travels back from the VRAM.
      RD: begin
        ram_addr = pal_addr;
        if (lat_q == LAT_LAST) state_d = MERGE;
        else                   lat_d   = lat_q + 2'd1;
      end

      MERGE: begin
        ram_addr  = pal_addr;
        ram_we    = 1'b1;
        done      = 1'b1;
        ram_wdata = sel_q ? {ram_rdata[7:4], data_q[3:0]}
                          : {data_q[3:0], ram_rdata[3:0]};
        state_d   = IDLE;
      end

      FILL: begin
        ram_addr  = {2'b10, cnt_q};
        ram_wdata = data_q;
        ram_we    = 1'b1;
        if (cnt_q == 11'h7FF) begin
          done    = 1'b1;
          cnt_d   = 11'd0;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + 11'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 11'd0;
      lat_q   <= 2'd0;
      op_q    <= 2'd0;
      col_q   <= 6'd0;
      row_q   <= 5'd0;
      sel_q   <= 1'b0;
      addr_q  <= 11'd0;
      data_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      op_q    <= op_d;
      col_q   <= col_d;
      row_q   <= row_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule
